// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB writeback stage.
package wb_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_LOAD = 2'd1,
    RES_PC4  = 2'd2,
    RES_IMM  = 2'd3
  } res_src_e;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Combinational load extraction: picks byte/halfword/word from an aligned
// memory word and sign- or zero-extends it to XLEN.
module load_formatter
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[8*i_offset +: 8];
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_result = '0;
    case (i_funct3)
      LD_B:    o_result = XLEN'($signed(w_byte));
      LD_BU:   o_result = XLEN'(w_byte);
      LD_H:    o_result = XLEN'($signed(w_half));
      LD_HU:   o_result = XLEN'(w_half);
      // Wider datapaths treat LW as a signed 32-bit load.
      LD_W:    o_result = XLEN'($signed(i_word[31:0]));
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback result mux for the RV32 core.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
  import wb_pkg::*;
#(
  parameter  int XLEN       = XLEN_DEF,
  parameter  int NUM_SRC    = 4,
  parameter  int REG_ADDR_W = 5,
  localparam int SRC_W      = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Stall_W,
  input  logic                  Flush_W,
  input  logic                  Valid_M,
  input  logic                  RegWrite_M,
  input  logic [SRC_W-1:0]      ResultSrc_M,
  input  logic [2:0]            LoadType_M,
  input  logic [XLEN-1:0]       ALUResult_M,
  input  logic [XLEN-1:0]       ReadData_M,
  input  logic [XLEN-1:0]       PCPlus4_M,
  input  logic [XLEN-1:0]       ImmExt_M,
  input  logic [REG_ADDR_W-1:0] Rd_M,
  output logic [XLEN-1:0]       Result_W,
  output logic [REG_ADDR_W-1:0] Rd_W,
  output logic                  RegWrite_W,
  output logic                  Valid_W
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           RetireCount_W
`endif
);

  logic                  r_valid;
  logic                  r_regwrite;
  logic [SRC_W-1:0]      r_src;
  logic [2:0]            r_funct3;
  logic [XLEN-1:0]       r_alu;
  logic [XLEN-1:0]       r_rdata;
  logic [XLEN-1:0]       r_pc4;
  logic [XLEN-1:0]       r_imm;
  logic [REG_ADDR_W-1:0] r_rd;

  logic [XLEN-1:0]       w_load;
  logic [1:0]            w_src2;

  // Flush beats stall; data registers follow the M inputs on a flush too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_src      <= '0;
      r_funct3   <= '0;
      r_alu      <= '0;
      r_rdata    <= '0;
      r_pc4      <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
    end else if (Flush_W || !Stall_W) begin
      r_valid    <= Flush_W ? 1'b0 : Valid_M;
      r_regwrite <= Flush_W ? 1'b0 : RegWrite_M;
      r_src      <= ResultSrc_M;
      r_funct3   <= LoadType_M;
      r_alu      <= ALUResult_M;
      r_rdata    <= ReadData_M;
      r_pc4      <= PCPlus4_M;
      r_imm      <= ImmExt_M;
      r_rd       <= Rd_M;
    end
  end

  load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .i_word   (r_rdata),
    .i_offset (r_alu[1:0]),
    .i_funct3 (r_funct3),
    .o_result (w_load)
  );

  always_comb begin
    w_src2   = 2'(r_src);
    Result_W = '0;
    if ({30'd0, w_src2} < 32'(NUM_SRC)) begin
      case (w_src2)
        RES_ALU:  Result_W = r_alu;
        RES_LOAD: Result_W = w_load;
        RES_PC4:  Result_W = r_pc4;
        RES_IMM:  Result_W = r_imm;
        default:  Result_W = '0;
      endcase
    end
  end

  assign Valid_W    = r_valid;
  assign Rd_W       = r_rd;
  assign RegWrite_W = r_regwrite & r_valid & (r_rd != '0);

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_retire_cnt;

  // An instruction retires on the edge that moves it out of WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (r_valid && !Stall_W) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

  assign RetireCount_W = r_retire_cnt;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage (NUM_SRC=4 and NUM_SRC=3).
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_w, flush_w, valid_m, regwrite_m;
  logic [1:0]  src_m;
  logic [2:0]  ld_m;
  logic [31:0] alu_m, rdata_m, pc4_m, imm_m;
  logic [4:0]  rd_m;
  logic [31:0] result_w, result3_w;
  logic [4:0]  rd_w, rd3_w;
  logic        regwrite_w, regwrite3_w, valid_w, valid3_w;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt_w, cnt3_w;
`endif

  int errors = 0;
  int checks = 0;

  writeback_stage #(.XLEN(32), .NUM_SRC(4), .REG_ADDR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .Stall_W(stall_w), .Flush_W(flush_w),
    .Valid_M(valid_m), .RegWrite_M(regwrite_m), .ResultSrc_M(src_m),
    .LoadType_M(ld_m), .ALUResult_M(alu_m), .ReadData_M(rdata_m),
    .PCPlus4_M(pc4_m), .ImmExt_M(imm_m), .Rd_M(rd_m),
    .Result_W(result_w), .Rd_W(rd_w), .RegWrite_W(regwrite_w), .Valid_W(valid_w)
`ifdef WB_RETIRE_CNT_EN
    , .RetireCount_W(cnt_w)
`endif
  );

  writeback_stage #(.XLEN(32), .NUM_SRC(3), .REG_ADDR_W(5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .Stall_W(stall_w), .Flush_W(flush_w),
    .Valid_M(valid_m), .RegWrite_M(regwrite_m), .ResultSrc_M(src_m),
    .LoadType_M(ld_m), .ALUResult_M(alu_m), .ReadData_M(rdata_m),
    .PCPlus4_M(pc4_m), .ImmExt_M(imm_m), .Rd_M(rd_m),
    .Result_W(result3_w), .Rd_W(rd3_w), .RegWrite_W(regwrite3_w), .Valid_W(valid3_w)
`ifdef WB_RETIRE_CNT_EN
    , .RetireCount_W(cnt3_w)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        rw;
    logic [1:0]  src;
    logic [2:0]  ld;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] exp_res;
    logic        exp_rw;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] s, input logic [2:0] l,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                       input logic [31:0] i, input logic [4:0] r);
    valid_m = v; regwrite_m = rw; src_m = s; ld_m = l;
    alu_m = a; rdata_m = d; pc4_m = p; imm_m = i; rd_m = r;
  endtask

  task automatic add(input string n, input logic v, input logic rw, input logic [1:0] s,
                     input logic [2:0] l, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] p, input logic [31:0] i, input logic [4:0] r,
                     input logic [31:0] er, input logic erw, input logic ev);
    vec_t t;
    t.name = n; t.valid = v; t.rw = rw; t.src = s; t.ld = l; t.alu = a; t.rdata = d;
    t.pc4 = p; t.imm = i; t.rd = r; t.exp_res = er; t.exp_rw = erw; t.exp_valid = ev;
    vecs.push_back(t);
  endtask

  initial begin
    logic [31:0] exp3;

    add("lb_off2",   1, 1, 2'd1, 3'b000, 32'h1002, 32'h80FF_0012, 32'h0, 32'h0, 5'd3, 32'hFFFF_FFFF, 1, 1);
    add("lbu_off2",  1, 1, 2'd1, 3'b100, 32'h1002, 32'h80FF_0012, 32'h0, 32'h0, 5'd3, 32'h0000_00FF, 1, 1);
    add("lb_off3",   1, 1, 2'd1, 3'b000, 32'h1003, 32'h80FF_0012, 32'h0, 32'h0, 5'd4, 32'hFFFF_FF80, 1, 1);
    add("lb_off0",   1, 1, 2'd1, 3'b000, 32'h1000, 32'h80FF_0012, 32'h0, 32'h0, 5'd4, 32'h0000_0012, 1, 1);
    add("lh_hi",     1, 1, 2'd1, 3'b001, 32'h2003, 32'h8001_7FFF, 32'h0, 32'h0, 5'd6, 32'hFFFF_8001, 1, 1);
    add("lhu_hi",    1, 1, 2'd1, 3'b101, 32'h2002, 32'h8001_7FFF, 32'h0, 32'h0, 5'd6, 32'h0000_8001, 1, 1);
    add("lh_lo",     1, 1, 2'd1, 3'b001, 32'h2001, 32'h8001_7FFF, 32'h0, 32'h0, 5'd6, 32'h0000_7FFF, 1, 1);
    add("lw",        1, 1, 2'd1, 3'b010, 32'h2003, 32'h8001_7FFF, 32'h0, 32'h0, 5'd7, 32'h8001_7FFF, 1, 1);
    add("ld_bad",    1, 1, 2'd1, 3'b011, 32'h2000, 32'h8001_7FFF, 32'h0, 32'h0, 5'd7, 32'h0000_0000, 1, 1);
    add("alu",       1, 1, 2'd0, 3'b000, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 5'd9, 32'hDEAD_BEEF, 1, 1);
    add("pc4",       1, 1, 2'd2, 3'b000, 32'h5, 32'h1, 32'h104, 32'h3, 5'd1, 32'h0000_0104, 1, 1);
    add("imm",       1, 1, 2'd3, 3'b000, 32'h5, 32'h1, 32'h104, 32'h1234_5000, 5'd2, 32'h1234_5000, 1, 1);
    add("x0_write",  1, 1, 2'd0, 3'b000, 32'h77, 32'h1, 32'h2, 32'h3, 5'd0, 32'h0000_0077, 0, 1);
    add("no_rw",     1, 0, 2'd0, 3'b000, 32'h88, 32'h1, 32'h2, 32'h3, 5'd8, 32'h0000_0088, 0, 1);
    add("invalid",   0, 1, 2'd0, 3'b000, 32'h99, 32'h1, 32'h2, 32'h3, 5'd8, 32'h0000_0099, 0, 0);

    rst_n = 1'b0; stall_w = 0; flush_w = 0;
    drive(0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    #12;
    chk("rst_valid", 32'(valid_w), 32'h0);
    chk("rst_rw", 32'(regwrite_w), 32'h0);
    chk("rst_rd", 32'(rd_w), 32'h0);
    chk("rst_result", result_w, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_reset", cnt_w[31:0], 32'h0);
`endif

    // driver + scoreboard over the vector table
    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].rw, vecs[k].src, vecs[k].ld, vecs[k].alu,
            vecs[k].rdata, vecs[k].pc4, vecs[k].imm, vecs[k].rd);
      step();
      chk({vecs[k].name, "_result"}, result_w, vecs[k].exp_res);
      chk({vecs[k].name, "_rw"}, 32'(regwrite_w), 32'(vecs[k].exp_rw));
      chk({vecs[k].name, "_valid"}, 32'(valid_w), 32'(vecs[k].exp_valid));
      chk({vecs[k].name, "_rd"}, 32'(rd_w), 32'(vecs[k].rd));
      exp3 = (vecs[k].src == 2'd3) ? 32'h0 : vecs[k].exp_res;
      chk({vecs[k].name, "_result_n3"}, result3_w, exp3);
    end

    // stall holds, then flush wins over stall
    drive(1, 1, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd5);
    step();
    chk("cap_result", result_w, 32'h1234);
    stall_w = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'd2, 3'd0, 32'hAAAA_0000 + 32'(i), 32'h0, 32'h500, 32'h0, 5'd10 + 5'(i));
      step();
      chk("stall_rd", 32'(rd_w), 32'd5);
      chk("stall_result", result_w, 32'h1234);
      chk("stall_rw", 32'(regwrite_w), 32'h1);
    end
    flush_w = 1;
    step();
    chk("flush_valid", 32'(valid_w), 32'h0);
    chk("flush_rw", 32'(regwrite_w), 32'h0);
    flush_w = 0; stall_w = 0;
    drive(1, 1, 2'd0, 3'd0, 32'h4321, 32'h0, 32'h0, 32'h0, 5'd11);
    step();
    chk("after_flush_result", result_w, 32'h4321);
    chk("after_flush_rw", 32'(regwrite_w), 32'h1);

    // asynchronous reset while an instruction sits in WB
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_w), 32'h0);
    chk("mid_rst_rw", 32'(regwrite_w), 32'h0);
    chk("mid_rst_result", result_w, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef WB_RETIRE_CNT_EN
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 2'd0, 3'd0, 32'(i), 32'h0, 32'h0, 32'h0, 5'd1);
      step();
      if (i == 4) begin
        stall_w = 1;
        step();
        step();
        stall_w = 0;
      end
    end
    drive(0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    step();
    chk("retire_cnt", cnt_w[31:0], 32'd10);
    chk("retire_cnt_hi", cnt_w[63:32], 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
